hog_cell_hist: RTL and testbench
================================

# hog_cell_hist

Per-cell orientation histogram accumulator for the HOG pipeline. It sits directly downstream of the orientation bin coder/counter. Each valid pixel adds its gradient magnitude into one of nine bins selected by the 4-bit bin code. On the cell-complete pulse it publishes the nine-bin histogram through a valid/ready output, then clears the bins for the next 8×8 cell.

## Interface
- `MAG_W`, 8: gradient magnitude width (unsigned)
- `NBIN`, 9: number of orientation bins (codes 0..8)
- `CNT_W`, 6: log2 of pixels per cell (64)
- `BIN_W`, `MAG_W+CNT_W` (14): per-bin accumulator width; cannot overflow
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `i_valid`  in  1  pixel sample valid
- `code`  in  4  bin code for this sample, same cycle as `i_valid`
- `mag`  in  MAG_W  gradient magnitude for this sample, same cycle as `i_valid`
- `cell_done`  in  1  one-cycle pulse from the bin counter; arrives the cycle after the 64th sample
- `o_valid`  out  1  histogram available
- `o_ready`  in  1  downstream accepts histogram
- `hist`  out  NBIN*BIN_W  flattened bins, bin k at `[k*BIN_W +: BIN_W]`
- `code_err`  out  1  sticky: a sample arrived with code > 8
- `ovf`  out  1  sticky: a cell completed while the previous histogram was still unaccepted

## Operation
- Accumulator bank `acc[0..8]` and output bank `hist_r[0..8]`, all BIN_W wide.
- Accumulate: `i_valid && code <= 8` gives `acc[code] <= acc[code] + mag`, zero-extended.
- Invalid code: `i_valid && code > 8` drops the sample and sets `code_err`.
- Publish on `cell_done`:
  - `hist_r <= acc`, `o_valid <= 1`.
  - All `acc` clear to 0, except the bin hit by a same-cycle valid sample, which loads `mag`.
  - That same-cycle sample counts toward the new cell.
- Output FSM, two states:
  - EMPTY (`o_valid=0`): goes to FULL on `cell_done`.
  - FULL (`o_valid=1`): `hist` is held stable. `o_ready` returns to EMPTY. If `cell_done` arrives in the same cycle as `o_ready`, the new histogram loads and the state stays FULL.
- Overflow: `cell_done` in FULL without `o_ready`:
  - new histogram overwrites `hist_r`, `o_valid` stays 1, `ovf` sets.
  - Newest data wins.
- `code_err` and `ovf` clear only on reset.
- Reset (any time, including mid-cell):
  - all `acc`, `hist_r` = 0; `o_valid`, `code_err`, `ovf` = 0; FSM = EMPTY.
  - A partially accumulated cell is discarded.

## Timing
- Sample to accumulator: 1 cycle (registered add).
- `cell_done` at edge t gives `o_valid=1` and valid `hist` after edge t.
- A transfer occurs at the edge where `o_valid && o_ready`. `o_valid` falls after that edge unless a new `cell_done` arrives in the same cycle.
- `o_ready` while EMPTY has no effect.
- Back-to-back cells (64 samples, pulse, next sample in the pulse cycle) sustain one sample per clock with no stall. The block has no input ready.
- `hist` outputs are direct register outputs; there is no combinational path from inputs to `hist`.

## Structure
- Shared HOG package holds:
  - `NBIN`, `CNT_W`, `MAG_W`, `BIN_W`;
  - the bin-code type (4 bit) and the constant `MAX_CODE = 8`;
  - the flattened histogram type, so the block-normalisation stage uses the same layout.
- One sub-module is natural: `hog_bin_acc`, a single bin register with add-enable and clear/load. Instantiate it NBIN times with a generate loop, enable = `i_valid && code == k`.
- The output FSM and sticky flags live in the top.

## Test plan
- **Single cell:** 64 samples, code = i%9, mag = 10, then `cell_done`, `o_ready=1`.
  - Bin 0 = 80, bins 1..8 = 70.
  - `o_valid` high exactly one cycle after the pulse.
- **Saturation range:** 64 samples, code 4, mag 255, then pulse.
  - `hist` bin 4 = 16320, all others 0, no wrap.
- **Back-to-back:** first cell all code 2, mag 1. The pulse coincides with the next cell's first sample (code 7, mag 5).
  - First histogram: bin 2 = 64.
  - Second cell bin 7 includes the 5.
- **Backpressure:** hold `o_ready=0` across two `cell_done` pulses.
  - `ovf`=1, `hist` shows the second cell.
  - After `o_ready`, `o_valid` drops.
- **Bad code:** a sample with code 12, mag 50.
  - No bin changes, `code_err`=1 and it stays set.
- **Reset mid-cell:** after 30 samples, pulse `rst` low asynchronously between edges.
  - All outputs go 0 immediately.
  - The next full cell reports only post-reset samples.

Source files
------------

// File: rtl/hog_cell_hist_pkg.sv
// Shared HOG definitions: bin geometry, bin-code type and the flattened
// histogram layout used by this block and the block-normalisation stage.
package hog_cell_hist_pkg;

  localparam int MAG_W = 8;
  localparam int NBIN  = 9;
  localparam int CNT_W = 6;
  localparam int BIN_W = MAG_W + CNT_W;

  typedef logic [3:0] bin_code_t;
  localparam bin_code_t MAX_CODE = 4'd8;

  typedef logic [NBIN*BIN_W-1:0] hist_flat_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } out_state_e;

endpackage

// File: rtl/hog_bin_acc.sv
// One orientation-bin accumulator: add-enable, and clear on cell boundary
// (loading the same-cycle sample so back-to-back cells lose nothing).
module hog_bin_acc
  import hog_cell_hist_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             add_en_i,
  input  logic             clr_i,
  input  logic [MAG_W-1:0] mag_i,
  output logic [BIN_W-1:0] acc_o
);

  logic [BIN_W-1:0] acc_q, acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = add_en_i ? BIN_W'(mag_i) : '0;
    end else if (add_en_i) begin
      acc_d = acc_q + BIN_W'(mag_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/hog_cell_hist.sv
// Per-cell nine-bin orientation histogram: accumulates magnitudes per bin and
// publishes the cell histogram through a valid/ready register stage.
module hog_cell_hist
  import hog_cell_hist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  bin_code_t        code,
  input  logic [MAG_W-1:0] mag,
  input  logic             cell_done,
  output logic             o_valid,
  input  logic             o_ready,
  output hist_flat_t       hist,
  output logic             code_err,
  output logic             ovf
);

  hist_flat_t acc_flat;
  hist_flat_t hist_q, hist_d;
  out_state_e state_q, state_d;
  logic       code_err_q, code_err_d;
  logic       ovf_q, ovf_d;

  for (genvar k = 0; k < NBIN; k++) begin : g_bin
    hog_bin_acc u_acc (
      .clk_i    (clk),
      .rst_ni   (rst),
      .add_en_i (i_valid && (code == bin_code_t'(k))),
      .clr_i    (cell_done),
      .mag_i    (mag),
      .acc_o    (acc_flat[k*BIN_W +: BIN_W])
    );
  end

  always_comb begin
    state_d    = state_q;
    hist_d     = hist_q;
    ovf_d      = ovf_q;
    code_err_d = code_err_q | (i_valid && (code > MAX_CODE));
    if (cell_done) begin
      hist_d = acc_flat;
    end
    case (state_q)
      ST_EMPTY: begin
        if (cell_done) state_d = ST_FULL;
      end
      ST_FULL: begin
        // A new cell while the old one is unaccepted overwrites it; newest wins.
        if (cell_done) begin
          state_d = ST_FULL;
          if (!o_ready) ovf_d = 1'b1;
        end else if (o_ready) begin
          state_d = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      hist_q     <= '0;
      code_err_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hist_q     <= hist_d;
      code_err_q <= code_err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign o_valid  = (state_q == ST_FULL);
  assign hist     = hist_q;
  assign code_err = code_err_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_hog_cell_hist.sv
// Directed plus randomized bench for hog_cell_hist against a bin-array model.
module tb_hog_cell_hist;
  import hog_cell_hist_pkg::*;

  logic             clk;
  logic             rst;
  logic             i_valid;
  bin_code_t        code;
  logic [MAG_W-1:0] mag;
  logic             cell_done;
  logic             o_valid;
  logic             o_ready;
  hist_flat_t       hist;
  logic             code_err;
  logic             ovf;

  int total = 0;
  int passed = 0;

  int m_acc  [NBIN];
  int m_hist [NBIN];
  bit m_valid, m_ovf, m_cerr;

  hog_cell_hist dut (
    .clk       (clk),
    .rst       (rst),
    .i_valid   (i_valid),
    .code      (code),
    .mag       (mag),
    .cell_done (cell_done),
    .o_valid   (o_valid),
    .o_ready   (o_ready),
    .hist      (hist),
    .code_err  (code_err),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int bin_of(int k);
    return int'(hist[k*BIN_W +: BIN_W]);
  endfunction

  task automatic chk(string tag, int obs, int exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < NBIN; k++) begin
      m_acc[k]  = 0;
      m_hist[k] = 0;
    end
    m_valid = 0; m_ovf = 0; m_cerr = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".o_valid"}, int'(o_valid), int'(m_valid));
    chk({tag, ".ovf"}, int'(ovf), int'(m_ovf));
    chk({tag, ".code_err"}, int'(code_err), int'(m_cerr));
    for (int k = 0; k < NBIN; k++)
      chk($sformatf("%s.bin%0d", tag, k), bin_of(k), m_hist[k]);
  endtask

  // Drive one clock of inputs, advance the model, then compare after the edge.
  task automatic cyc(bit v, int c, int m, bit done, bit rdy, string tag);
    i_valid = v; code = 4'(c); mag = 8'(m); cell_done = done; o_ready = rdy;
    if (done) begin
      if (m_valid && !rdy) m_ovf = 1;
      m_hist  = m_acc;
      m_valid = 1;
      for (int k = 0; k < NBIN; k++) m_acc[k] = 0;
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    if (v) begin
      if (c <= 8) m_acc[c] += m;
      else m_cerr = 1;
    end
    @(posedge clk);
    #1;
    i_valid = 0; cell_done = 0;
    check_all(tag);
  endtask

  initial begin
    int cnt;
    bit v, d, r;
    int c, m;
    rst = 1'b0; i_valid = 0; code = '0; mag = '0; cell_done = 0; o_ready = 0;
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b1;
    @(posedge clk); #1;

    // Single cell: code i%9, mag 10
    for (int i = 0; i < 64; i++) cyc(1, i % 9, 10, 0, 1, "single_acc");
    cyc(0, 0, 0, 1, 1, "single_pub");
    chk("single_b0", bin_of(0), 80);
    chk("single_b1", bin_of(1), 70);
    chk("single_b8", bin_of(8), 70);
    chk("single_vld", int'(o_valid), 1);
    cyc(0, 0, 0, 0, 1, "single_drain");
    chk("single_vld_drop", int'(o_valid), 0);

    // Full-scale magnitudes into one bin
    for (int i = 0; i < 64; i++) cyc(1, 4, 255, 0, 1, "sat_acc");
    cyc(0, 0, 0, 1, 1, "sat_pub");
    chk("sat_b4", bin_of(4), 16320);
    chk("sat_b3", bin_of(3), 0);
    cyc(0, 0, 0, 0, 1, "sat_drain");

    // Back-to-back: next cell's first sample in the pulse cycle
    for (int i = 0; i < 64; i++) cyc(1, 2, 1, 0, 1, "b2b_acc1");
    cyc(1, 7, 5, 1, 1, "b2b_pub1");
    chk("b2b_b2", bin_of(2), 64);
    chk("b2b_b7_first", bin_of(7), 0);
    for (int i = 0; i < 63; i++) cyc(1, 7, 1, 0, 1, "b2b_acc2");
    cyc(0, 0, 0, 1, 1, "b2b_pub2");
    chk("b2b_b7", bin_of(7), 68);
    cyc(0, 0, 0, 0, 1, "b2b_drain");

    // Bad code
    cyc(1, 12, 50, 0, 1, "bad_code");
    chk("bad_cerr", int'(code_err), 1);
    for (int i = 0; i < 5; i++) cyc(1, 3, 2, 0, 1, "bad_after");
    cyc(0, 0, 0, 1, 1, "bad_pub");
    chk("bad_b3", bin_of(3), 10);
    chk("bad_cerr_sticky", int'(code_err), 1);
    cyc(0, 0, 0, 0, 1, "bad_drain");

    // Backpressure across two pulses
    for (int i = 0; i < 64; i++) cyc(1, 1, 3, 0, 0, "bp_acc1");
    cyc(0, 0, 0, 1, 0, "bp_pub1");
    for (int i = 0; i < 64; i++) cyc(1, 5, 2, 0, 0, "bp_acc2");
    cyc(0, 0, 0, 1, 0, "bp_pub2");
    chk("bp_ovf", int'(ovf), 1);
    chk("bp_b5", bin_of(5), 128);
    chk("bp_b1", bin_of(1), 0);
    cyc(0, 0, 0, 0, 0, "bp_hold");
    chk("bp_hold_vld", int'(o_valid), 1);
    cyc(0, 0, 0, 0, 1, "bp_accept");
    chk("bp_vld_drop", int'(o_valid), 0);

    // Asynchronous reset mid-cell
    for (int i = 0; i < 30; i++) cyc(1, 6, 9, 0, 1, "rst_pre");
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("rst_async");
    #1 rst = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) cyc(1, 0, 3, 0, 1, "rst_post");
    cyc(0, 0, 0, 1, 1, "rst_pub");
    chk("rst_b0", bin_of(0), 192);
    chk("rst_b6", bin_of(6), 0);
    cyc(0, 0, 0, 0, 1, "rst_drain");

    // Randomized traffic, at most 64 samples per cell
    cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      v = ($urandom_range(0, 3) != 0);
      c = ($urandom_range(0, 19) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
      m = $urandom_range(0, 255);
      d = ($urandom_range(0, 24) == 0) || (cnt >= 63);
      r = ($urandom_range(0, 2) != 0);
      cyc(v, c, m, d, r, "rand");
      cnt = d ? 0 : cnt + 1;
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
